// File: rtl/img_ddr_burst_wr.sv
// Frame writer: drains the packet FIFO into one of four DDR frame buffers as fixed-length AXI4 INCR bursts.
// Optional performance counters are compiled in with `define IMG_DDR_WR_PERF_CNT_EN.
module img_ddr_burst_wr #(
    parameter int                ADDR_W      = 32,
    parameter int                BURST_LEN   = 16,
    parameter int                CNT_W       = 11,
    parameter int                FRAME_WORDS = 65536,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h1000_0000),
    parameter logic [ADDR_W-1:0] BUF_STRIDE  = ADDR_W'(32'h0010_0000)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [31:0]       fifo_rddata,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_rd_count,
    output logic              fifo_rden,
    input  logic              frame_store,
    input  logic [1:0]        frame_type_i,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic              frame_done,
    output logic [1:0]        frame_type_o,
    output logic              frame_abort,
    output logic              bresp_err,
    input  logic              clr_status
`ifdef IMG_DDR_WR_PERF_CNT_EN
    ,
    output logic [31:0]       perf_frame_cycles,
    output logic [31:0]       perf_wstall,
    output logic [15:0]       perf_bursts
`endif
);

    // state  | meaning
    // IDLE   | no frame active, FIFO left untouched
    // WAIT   | frame active, waiting for a full burst of words in the FIFO
    // AW     | address phase of the current burst
    // W      | data beats of the current burst
    // B      | waiting for the write response of the current burst

    localparam int                  BEAT_W      = $clog2(BURST_LEN);
    localparam int                  WC_W        = $clog2(FRAME_WORDS + 1);
    localparam logic [WC_W-1:0]     BURST_WORDS = WC_W'(BURST_LEN);
    localparam logic [WC_W-1:0]     FRAME_LAST  = WC_W'(FRAME_WORDS);
    localparam logic [BEAT_W-1:0]   LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [CNT_W:0]      BURST_CNT   = (CNT_W + 1)'(BURST_LEN);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_AW, S_W, S_B} state_t;

    state_t              state, state_nxt;
    logic [1:0]          cur_type;
    logic [1:0]          pend_type;
    logic                pend_vld;
    logic [WC_W-1:0]     word_cnt;
    logic [WC_W-1:0]     word_nxt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [ADDR_W-1:0]   awaddr_q;
    logic                cnt_ok;
    logic                w_hs;
    logic                b_hs;
    logic                beat_last;
    logic                frame_end;
    logic                abort_set;
    logic                err_set;

    assign cnt_ok    = {1'b0, fifo_rd_count} >= BURST_CNT;
    assign w_hs      = m_axi_wvalid && m_axi_wready;
    assign b_hs      = (state == S_B) && m_axi_bvalid;
    assign beat_last = (beat_cnt == LAST_BEAT);
    assign word_nxt  = word_cnt + BURST_WORDS;
    assign frame_end = (word_nxt == FRAME_LAST);

    // A store that lands on the final response starts a fresh frame cleanly; any other mid-frame store aborts.
    assign abort_set = frame_store && (state != S_IDLE) && !(b_hs && frame_end && !pend_vld);
    assign err_set   = b_hs && (m_axi_bresp != 2'b00);

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = 4'hF;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (frame_store) state_nxt = S_WAIT;
            S_WAIT: if (cnt_ok) state_nxt = S_AW;
            S_AW:   if (m_axi_awready) state_nxt = S_W;
            S_W:    if (w_hs && beat_last) state_nxt = S_B;
            S_B: begin
                if (m_axi_bvalid) begin
                    state_nxt = (frame_end && !pend_vld && !frame_store) ? S_IDLE : S_WAIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        m_axi_awvalid = (state == S_AW);
        m_axi_wvalid  = (state == S_W) && !fifo_empty;
        m_axi_wdata   = (state == S_W) ? fifo_rddata : 32'h0;
        m_axi_wlast   = (state == S_W) && beat_last;
        m_axi_bready  = (state == S_B);
        fifo_rden     = (state == S_W) && !fifo_empty && m_axi_wready;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cur_type     <= 2'd0;
            word_cnt     <= '0;
            awaddr_q     <= '0;
            frame_done   <= 1'b0;
            frame_type_o <= 2'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_store) begin
                        cur_type <= frame_type_i;
                        word_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (cnt_ok) begin
                        awaddr_q <= BASE_ADDR + ADDR_W'(cur_type) * BUF_STRIDE
                                    + (ADDR_W'(word_cnt) << 2);
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        if (frame_store) begin
                            if (frame_end && !pend_vld) begin
                                frame_done   <= 1'b1;
                                frame_type_o <= cur_type;
                            end
                            cur_type <= frame_type_i;
                            word_cnt <= '0;
                        end else if (pend_vld) begin
                            cur_type <= pend_type;
                            word_cnt <= '0;
                        end else if (frame_end) begin
                            frame_done   <= 1'b1;
                            frame_type_o <= cur_type;
                            word_cnt     <= '0;
                        end else begin
                            word_cnt <= word_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt  <= '0;
            pend_vld  <= 1'b0;
            pend_type <= 2'd0;
        end else begin
            if (w_hs) begin
                beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
            end
            if (b_hs) begin
                pend_vld <= 1'b0;
            end else if (frame_store && (state != S_IDLE)) begin
                pend_vld  <= 1'b1;
                pend_type <= frame_type_i;
            end
        end
    end

    // Sticky status: a new event outranks a simultaneous clear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_abort <= 1'b0;
            bresp_err   <= 1'b0;
        end else begin
            if (abort_set) begin
                frame_abort <= 1'b1;
            end else if (clr_status) begin
                frame_abort <= 1'b0;
            end
            if (err_set) begin
                bresp_err <= 1'b1;
            end else if (clr_status) begin
                bresp_err <= 1'b0;
            end
        end
    end

`ifdef IMG_DDR_WR_PERF_CNT_EN
    logic        frame_start;
    logic        frame_fin;
    logic [31:0] run_cycles;
    logic [31:0] run_wstall;
    logic [15:0] run_bursts;

    assign frame_start = ((state == S_IDLE) && frame_store) || (b_hs && (frame_store || pend_vld));
    assign frame_fin   = b_hs && frame_end && !pend_vld;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_cycles        <= 32'd0;
            run_wstall        <= 32'd0;
            run_bursts        <= 16'd0;
            perf_frame_cycles <= 32'd0;
            perf_wstall       <= 32'd0;
            perf_bursts       <= 16'd0;
        end else begin
            // Published together with the frame_done pulse of the completed frame.
            if (frame_fin) begin
                perf_frame_cycles <= run_cycles + 32'd1;
                perf_wstall       <= run_wstall;
                perf_bursts       <= run_bursts;
            end
            if (frame_start) begin
                run_cycles <= 32'd0;
                run_wstall <= 32'd0;
                run_bursts <= 16'd0;
            end else if (state != S_IDLE) begin
                run_cycles <= run_cycles + 32'd1;
                if ((state == S_W) && ((m_axi_wvalid && !m_axi_wready) || fifo_empty)) begin
                    run_wstall <= run_wstall + 32'd1;
                end
                if ((state == S_AW) && m_axi_awready) begin
                    run_bursts <= run_bursts + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_img_ddr_burst_wr.sv
// Directed bench for img_ddr_burst_wr with a 64-word frame of four 16-beat bursts.
module tb_img_ddr_burst_wr;

    localparam int          ADDR_W      = 32;
    localparam int          BURST_LEN   = 16;
    localparam int          CNT_W       = 11;
    localparam int          FRAME_WORDS = 64;
    localparam logic [31:0] DATA0       = 32'hA500_0000;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [31:0]       fifo_rddata;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_rd_count;
    logic              fifo_rden;
    logic              frame_store = 1'b0;
    logic [1:0]        frame_type_i = 2'd0;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [7:0]        m_axi_awlen;
    logic [2:0]        m_axi_awsize;
    logic [1:0]        m_axi_awburst;
    logic              m_axi_awvalid;
    logic              m_axi_awready = 1'b1;
    logic [31:0]       m_axi_wdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wlast;
    logic              m_axi_wvalid;
    logic              m_axi_wready = 1'b1;
    logic [1:0]        m_axi_bresp = 2'b00;
    logic              m_axi_bvalid = 1'b0;
    logic              m_axi_bready;
    logic              frame_done;
    logic [1:0]        frame_type_o;
    logic              frame_abort;
    logic              bresp_err;
    logic              clr_status = 1'b0;

    // FWFT FIFO model: word k pushed carries DATA0 + k.
    logic [31:0]      mem [0:1023];
    logic [15:0]      wr_ptr = 16'd0;
    logic [15:0]      rd_ptr = 16'd0;
    logic             cnt_ovr_en = 1'b0;
    logic [CNT_W-1:0] cnt_ovr = '0;

    int          aw_cnt = 0;
    int          w_cnt = 0;
    int          b_cnt = 0;
    int          done_cnt = 0;
    int          rden_bad = 0;
    logic [1:0]  done_type = 2'd0;
    logic [31:0] aw_log [0:63];
    logic [31:0] w_data [0:1023];
    logic        w_last [0:1023];
    bit          b_pend = 1'b0;
    bit          wr_toggle = 1'b0;
    int          err_b = -1;

    int total = 0;
    int bad = 0;

    img_ddr_burst_wr #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST_LEN),
        .CNT_W       (CNT_W),
        .FRAME_WORDS (FRAME_WORDS),
        .BASE_ADDR   (32'h1000_0000),
        .BUF_STRIDE  (32'h0010_0000)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .fifo_rddata   (fifo_rddata),
        .fifo_empty    (fifo_empty),
        .fifo_rd_count (fifo_rd_count),
        .fifo_rden     (fifo_rden),
        .frame_store   (frame_store),
        .frame_type_i  (frame_type_i),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .frame_done    (frame_done),
        .frame_type_o  (frame_type_o),
        .frame_abort   (frame_abort),
        .bresp_err     (bresp_err),
        .clr_status    (clr_status)
    );

    always #5 aclk = ~aclk;

    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_rddata   = mem[rd_ptr[9:0]];
    assign fifo_rd_count = cnt_ovr_en ? cnt_ovr : CNT_W'(wr_ptr - rd_ptr);

    always @(posedge aclk) begin
        if (fifo_rden) rd_ptr <= rd_ptr + 16'd1;
    end

    // Slave responder and monitor: drive at the falling edge, record the handshakes the next rising edge will take.
    always @(negedge aclk) begin
        if (!aresetn) begin
            m_axi_bvalid = 1'b0;
            b_pend = 1'b0;
        end else begin
            m_axi_wready = wr_toggle ? ~m_axi_wready : 1'b1;
            m_axi_bvalid = b_pend;
            m_axi_bresp  = (b_cnt == err_b) ? 2'b10 : 2'b00;
        end
        #1;
        if (aresetn) begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_log[aw_cnt] = m_axi_awaddr;
                aw_cnt++;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_data[w_cnt] = m_axi_wdata;
                w_last[w_cnt] = m_axi_wlast;
                w_cnt++;
                if (m_axi_wlast) b_pend = 1'b1;
            end
            if (fifo_rden !== (m_axi_wvalid && m_axi_wready)) rden_bad++;
            if (m_axi_bvalid && m_axi_bready) begin
                b_cnt++;
                b_pend = 1'b0;
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                done_type = frame_type_o;
            end
        end
    end

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[9:0]] = DATA0 + 32'(wr_ptr);
            wr_ptr = wr_ptr + 16'd1;
        end
    endtask

    task automatic pulse_store(input logic [1:0] t);
        @(negedge aclk);
        frame_type_i = t;
        frame_store  = 1'b1;
        @(negedge aclk);
        frame_store  = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit ok);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        ok = (done_cnt >= target);
        repeat (10) @(negedge aclk);
    endtask

    task automatic test_reset();
        logic [7:0]  obs;
        logic [16:0] cst;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        obs = {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, fifo_rden, m_axi_bready, frame_done, frame_abort, bresp_err};
        total++;
        if (obs !== 8'h00) begin bad++; $display("FAIL reset_ctrl got=%b want=00000000", obs); end
        total++;
        if (m_axi_awaddr !== 32'h0 || m_axi_wdata !== 32'h0 || frame_type_o !== 2'd0) begin
            bad++; $display("FAIL reset_data awaddr=%h wdata=%h type=%0d want all 0", m_axi_awaddr, m_axi_wdata, frame_type_o);
        end
        cst = {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wstrb};
        total++;
        if (cst !== {8'h0F, 3'b010, 2'b01, 4'hF}) begin bad++; $display("FAIL reset_const got=%h want=%h", cst, {8'h0F, 3'b010, 2'b01, 4'hF}); end
        @(posedge aclk);
        #3 aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        #2;
        obs = {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, fifo_rden, m_axi_bready, frame_done, frame_abort, bresp_err};
        total++;
        if (obs !== 8'h00) begin bad++; $display("FAIL post_reset_idle got=%b want=00000000", obs); end
    endtask

    task automatic test_basic_frame();
        int a0 = aw_cnt, w0 = w_cnt, d0 = done_cnt, e = 0;
        logic [15:0] r0;
        bit ok;
        push_words(64);
        r0 = rd_ptr;
        repeat (6) @(negedge aclk);
        total++;
        if (rd_ptr !== r0 || aw_cnt != a0) begin bad++; $display("FAIL idle_no_pop rd_ptr=%0d want=%0d aw=%0d", rd_ptr, r0, aw_cnt - a0); end
        pulse_store(2'd2);
        wait_done(d0 + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_timeout done_cnt=%0d want=%0d", done_cnt, d0 + 1); end
        total++;
        if (aw_cnt - a0 != 4 || w_cnt - w0 != 64) begin bad++; $display("FAIL basic_counts bursts=%0d beats=%0d want 4 64", aw_cnt - a0, w_cnt - w0); end
        for (int i = 0; i < 4; i++) if (aw_log[a0 + i] !== 32'h1020_0000 + 32'(i * 64)) e++;
        total++;
        if (e != 0) begin bad++; $display("FAIL basic_awaddr bad=%0d first=%h want=10200000 step 40", e, aw_log[a0]); end
        e = 0;
        for (int j = 0; j < 64; j++) if (w_data[w0 + j] !== DATA0 + 32'(w0 + j) || w_last[w0 + j] !== (j % 16 == 15)) e++;
        total++;
        if (e != 0) begin bad++; $display("FAIL basic_wdata bad_beats=%0d want 0", e); end
        total++;
        if (done_cnt != d0 + 1 || done_type !== 2'd2) begin bad++; $display("FAIL basic_done count=%0d type=%0d want 1 2", done_cnt - d0, done_type); end
    endtask

    task automatic test_count_threshold();
        int a0 = aw_cnt, d0 = done_cnt;
        bit seen = 1'b0, ok;
        cnt_ovr_en = 1'b1;
        cnt_ovr    = CNT_W'(15);
        push_words(64);
        pulse_store(2'd0);
        repeat (10) begin
            @(negedge aclk);
            #1;
            if (m_axi_awvalid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen || aw_cnt != a0) begin bad++; $display("FAIL cnt15_awvalid got=1 want=0"); end
        @(negedge aclk);
        cnt_ovr = CNT_W'(16);
        #1;
        total++;
        if (m_axi_awvalid !== 1'b0) begin bad++; $display("FAIL cnt16_same_cycle awvalid=%b want=0", m_axi_awvalid); end
        @(negedge aclk);
        #1;
        total++;
        if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 32'h1000_0000) begin
            bad++; $display("FAIL cnt16_next_cycle awvalid=%b awaddr=%h want 1 10000000", m_axi_awvalid, m_axi_awaddr);
        end
        cnt_ovr_en = 1'b0;
        wait_done(d0 + 1, ok);
        total++;
        if (!ok || done_type !== 2'd0) begin bad++; $display("FAIL cnt_frame_done ok=%0d type=%0d want 1 0", ok, done_type); end
    endtask

    task automatic test_wready_toggle();
        int a0 = aw_cnt, w0 = w_cnt, d0 = done_cnt, e = 0, rb0 = rden_bad;
        bit ok;
        push_words(64);
        wr_toggle = 1'b1;
        pulse_store(2'd3);
        wait_done(d0 + 1, ok);
        wr_toggle = 1'b0;
        total++;
        if (!ok || done_type !== 2'd3) begin bad++; $display("FAIL toggle_done ok=%0d type=%0d want 1 3", ok, done_type); end
        total++;
        if (w_cnt - w0 != 64 || rden_bad != rb0) begin bad++; $display("FAIL toggle_rden beats=%0d rden_mismatch=%0d want 64 0", w_cnt - w0, rden_bad - rb0); end
        for (int j = 0; j < 64; j++) if (w_data[w0 + j] !== DATA0 + 32'(w0 + j) || w_last[w0 + j] !== (j % 16 == 15)) e++;
        for (int i = 0; i < 4; i++) if (aw_log[a0 + i] !== 32'h1030_0000 + 32'(i * 64)) e++;
        total++;
        if (e != 0) begin bad++; $display("FAIL toggle_stream bad=%0d want 0", e); end
    endtask

    task automatic test_bresp_err();
        int d0 = done_cnt;
        bit ok;
        total++;
        if (bresp_err !== 1'b0) begin bad++; $display("FAIL err_initial got=%b want=0", bresp_err); end
        push_words(64);
        err_b = b_cnt + 1;
        pulse_store(2'd1);
        wait_done(d0 + 1, ok);
        err_b = -1;
        total++;
        if (!ok || done_type !== 2'd1) begin bad++; $display("FAIL err_frame_done ok=%0d type=%0d want 1 1", ok, done_type); end
        total++;
        if (bresp_err !== 1'b1 || frame_abort !== 1'b0) begin bad++; $display("FAIL err_sticky err=%b abort=%b want 1 0", bresp_err, frame_abort); end
        @(negedge aclk);
        clr_status = 1'b1;
        @(negedge aclk);
        clr_status = 1'b0;
        #1;
        total++;
        if (bresp_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", bresp_err); end
    endtask

    task automatic test_abort();
        int a0 = aw_cnt, w0 = w_cnt, d0 = done_cnt, e = 0, n = 0;
        logic [31:0] exp_a [0:5];
        bit ok;
        exp_a = '{32'h1020_0000, 32'h1020_0040, 32'h1010_0000, 32'h1010_0040, 32'h1010_0080, 32'h1010_00C0};
        push_words(96);
        pulse_store(2'd2);
        while (aw_cnt < a0 + 2 && n < 500) begin
            @(negedge aclk);
            #2;
            n++;
        end
        total++;
        if (aw_cnt < a0 + 2) begin bad++; $display("FAIL abort_second_aw bursts=%0d want 2", aw_cnt - a0); end
        pulse_store(2'd1);
        #1;
        total++;
        if (frame_abort !== 1'b1) begin bad++; $display("FAIL abort_flag got=%b want=1", frame_abort); end
        wait_done(d0 + 1, ok);
        repeat (20) @(negedge aclk);
        total++;
        if (!ok || done_cnt != d0 + 1 || done_type !== 2'd1) begin
            bad++; $display("FAIL abort_done count=%0d type=%0d want 1 1", done_cnt - d0, done_type);
        end
        for (int i = 0; i < 6; i++) if (aw_log[a0 + i] !== exp_a[i]) e++;
        for (int j = 0; j < 96; j++) if (w_data[w0 + j] !== DATA0 + 32'(w0 + j) || w_last[w0 + j] !== (j % 16 == 15)) e++;
        total++;
        if (e != 0 || aw_cnt - a0 != 6) begin bad++; $display("FAIL abort_stream bad=%0d bursts=%0d third=%h want 0 6 10100000", e, aw_cnt - a0, aw_log[a0 + 2]); end
        @(negedge aclk);
        clr_status = 1'b1;
        @(negedge aclk);
        clr_status = 1'b0;
        #1;
        total++;
        if (frame_abort !== 1'b0) begin bad++; $display("FAIL abort_clear got=%b want=0", frame_abort); end
    endtask

    task automatic test_reset_mid();
        int ws = w_cnt, a0, w0, d0, e = 0, n = 0;
        logic [7:0] obs;
        bit ok;
        push_words(64);
        pulse_store(2'd0);
        while (w_cnt < ws + 5 && n < 500) begin
            @(posedge aclk);
            n++;
        end
        total++;
        if (w_cnt < ws + 5) begin bad++; $display("FAIL midrst_reach_w beats=%0d want 5", w_cnt - ws); end
        #1 aresetn = 1'b0;
        #1;
        obs = {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, fifo_rden, m_axi_bready, frame_done, frame_abort, bresp_err};
        total++;
        if (obs !== 8'h00 || m_axi_wdata !== 32'h0 || m_axi_awaddr !== 32'h0) begin
            bad++; $display("FAIL midrst_async ctrl=%b wdata=%h awaddr=%h want all 0", obs, m_axi_wdata, m_axi_awaddr);
        end
        repeat (2) @(posedge aclk);
        #3 aresetn = 1'b1;
        @(negedge aclk);
        a0 = aw_cnt;
        w0 = w_cnt;
        d0 = done_cnt;
        push_words(64);
        pulse_store(2'd3);
        wait_done(d0 + 1, ok);
        total++;
        if (!ok || done_type !== 2'd3) begin bad++; $display("FAIL midrst_done ok=%0d type=%0d want 1 3", ok, done_type); end
        for (int i = 0; i < 4; i++) if (aw_log[a0 + i] !== 32'h1030_0000 + 32'(i * 64)) e++;
        for (int j = 0; j < 64; j++) if (w_data[w0 + j] !== DATA0 + 32'(w0 + j) || w_last[w0 + j] !== (j % 16 == 15)) e++;
        total++;
        if (e != 0 || aw_cnt - a0 != 4) begin bad++; $display("FAIL midrst_stream bad=%0d bursts=%0d want 0 4", e, aw_cnt - a0); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_count_threshold();
        test_wready_toggle();
        test_bresp_err();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/img_ddr_burst_wr.md
Name: img_ddr_burst_wr

Overview:
- Downstream neighbour of the image pre-processing chain.
- Drains the 32-bit packet FIFO that the packetiser fills, and writes whole frames into DDR over an AXI4 write master as fixed-length INCR bursts.
- Each frame lands in one of four frame buffers, selected by the frame type that accompanies the frame-store pulse.
- Reports frame completion and error status to software/IRQ logic.

Parameters:
- ADDR_W, 32, AXI address width.
- BURST_LEN, 16, beats per burst; power of 2, 2..256.
- CNT_W, 11, width of the FIFO read-count input.
- FRAME_WORDS, 65536, 32-bit words per frame; must be a multiple of BURST_LEN.
- BASE_ADDR, 32'h1000_0000, address of frame buffer 0; aligned to 4 KB.
- BUF_STRIDE, 32'h0010_0000, byte offset between frame buffers; aligned to 4 KB.

Ports:
- aclk, in, 1, clock.
- aresetn, in, 1, asynchronous active-low reset.
- fifo_rddata, in, 32, FWFT FIFO head word; valid while fifo_empty=0.
- fifo_empty, in, 1, FIFO empty.
- fifo_rd_count, in, CNT_W, words currently readable.
- fifo_rden, out, 1, pops the head word.
- frame_store, in, 1, one-cycle pulse: a new frame is to be stored.
- frame_type_i, in, 2, buffer index; sampled with frame_store.
- m_axi_awaddr, out, ADDR_W, burst start address.
- m_axi_awlen, out, 8, BURST_LEN-1.
- m_axi_awsize, out, 3, constant 3'b010.
- m_axi_awburst, out, 2, constant 2'b01.
- m_axi_awvalid, in/out: out, 1.
- m_axi_awready, in, 1.
- m_axi_wdata, out, 32.
- m_axi_wstrb, out, 4, constant 4'hF.
- m_axi_wlast, out, 1.
- m_axi_wvalid, out, 1.
- m_axi_wready, in, 1.
- m_axi_bresp, in, 2.
- m_axi_bvalid, in, 1.
- m_axi_bready, out, 1.
- frame_done, out, 1, one-cycle pulse after the last burst's B response of a frame.
- frame_type_o, out, 2, buffer index of the completed frame; valid with frame_done.
- frame_abort, out, 1, sticky: a frame_store arrived while a frame was active.
- bresp_err, out, 1, sticky: a bresp other than OKAY was received.
- clr_status, in, 1, clears frame_abort and bresp_err.

Behaviour:
- Reset: all outputs 0 except the constant AXI fields; state IDLE; word counter 0.
- States:
  - IDLE: frame_store=1 latches cur_type=frame_type_i and sets word_cnt=0 -> WAIT.
  - WAIT: if fifo_rd_count>=BURST_LEN, register awaddr = BASE_ADDR + cur_type*BUF_STRIDE + word_cnt*4 and assert awvalid next cycle -> AW.
  - AW: hold awvalid and awaddr until awready; on the handshake -> W.
  - W: wvalid = ~fifo_empty; wdata = fifo_rddata; fifo_rden = wvalid & wready. Beat counter counts handshakes; wlast=1 on beat BURST_LEN-1. The wlast handshake -> B.
  - B: bready=1. On bvalid: word_cnt += BURST_LEN; bresp!=0 sets bresp_err.
    - If word_cnt reaches FRAME_WORDS: pulse frame_done with frame_type_o=cur_type -> IDLE.
    - Otherwise -> WAIT.
- Only one burst is outstanding at a time. W never starts before AW completes.
- Bursts never cross a 4 KB boundary; this is guaranteed by the parameter alignment rules.
- frame_store while not in IDLE:
  - Sets frame_abort.
  - Latches pending type; the current burst completes normally.
  - On that burst's B response, word_cnt resets to 0 and cur_type takes the pending type; no frame_done is issued.
  - Then -> WAIT.
- frame_store in the same cycle as the final B response: frame_done fires for the old frame and the new frame starts at word_cnt=0; frame_abort is not set.
- FIFO data arriving while in IDLE is not consumed.
- clr_status coincident with a new error event: the set wins.
- Reset asserted mid-burst: all outputs clear asynchronously. Recovery of the partially transferred burst is the interconnect reset's responsibility.
- Throughput: one beat per cycle when wready=1. There are 2 idle cycles between bursts (B -> WAIT -> AW).

Optional Feature:
- Macro IMG_DDR_WR_PERF_CNT_EN.
- When defined, adds three outputs:
  - perf_frame_cycles[31:0]: cycles from frame_store to frame_done of the last completed frame.
  - perf_wstall[31:0]: W-state cycles with wvalid&~wready or fifo_empty, for the last frame.
  - perf_bursts[15:0]: bursts issued in the last frame.
- Running counters reset at each frame start. The outputs update on frame_done.
- When not defined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- FRAME_WORDS=64, BURST_LEN=16, frame_store with type 2, FIFO preloaded with 64 words, all readies=1:
  - awaddr sequence 0x1020_0000, 0x1020_0040, 0x1020_0080, 0x1020_00C0.
  - 64 wdata beats in FIFO order, wlast on every 16th beat.
  - One frame_done with frame_type_o=2.
- FIFO count held at 15 -> no awvalid. Count raised to 16 -> awvalid 1 cycle later.
- wready toggling 50% -> wdata and fifo_rden stall in step, no word lost or duplicated, wlast still on the 16th handshake.
- bresp=2'b10 on the second burst -> bresp_err=1 and the frame still completes. clr_status -> bresp_err=0.
- frame_store type 1 during the second burst -> frame_abort=1, no frame_done. The next awaddr is 0x1010_0000.
- aresetn pulled low in the W state -> all outputs 0 asynchronously. A new frame_store after release works normally.
